// File: rtl/demux_rr_ctrl.sv
// Round-robin 1-to-4 demux controller: holds one item and steers it to a lane via {s0,s1}.
// Latency: item accepted at edge N is presented on out_valid from cycle N+1.
// Backpressure: in_ready is high when idle or when the held item is delivered this cycle.
// Optional macro DEMUX_RR_SKIP_EN: at capture, skip lanes that are not ready.
module demux_rr_ctrl #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [3:0]       out_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             s0,
    output logic             s1,
    output logic [7:0]       dcount
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       tgt;
    logic [WIDTH-1:0] hold;
    logic [7:0]       cnt;

    logic             deliver;
    logic [1:0]       base_ptr;
    logic [1:0]       pick;

    // Delivery only counts the ready bit of the lane we are holding for.
    assign deliver  = (state == HOLD) && out_ready[tgt];

    // A capture in the same cycle as a delivery must start from the advanced pointer.
    assign base_ptr = deliver ? (tgt + 2'd1) : ptr;

    // Lane choice for a capture this cycle.
`ifdef DEMUX_RR_SKIP_EN
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = base_ptr;
        found = 1'b0;
        idx   = base_ptr;
        for (int i = 0; i < 4; i++) begin
            idx = base_ptr + 2'(i);
            if (!found && out_ready[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = base_ptr;
    end
`endif

    // Upstream may hand over an item whenever the slot is free or being emptied.
    assign in_ready  = rst_n && ((state == IDLE) || deliver);

    // Outputs are pure decodes of registered state.
    assign out_valid = (state == HOLD) ? (4'b0001 << tgt) : 4'b0000;
    assign out_data  = hold;
    assign {s0, s1}  = (state == HOLD) ? tgt : ptr;
    assign dcount    = cnt;

    // Two-state hold FSM with round-robin pointer and delivery counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            tgt   <= 2'd0;
            hold  <= '0;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold  <= in_data;
                        tgt   <= pick;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (deliver) begin
                        ptr <= tgt + 2'd1;
                        cnt <= cnt + 8'd1;
                        if (in_valid) begin
                            hold <= in_data;
                            tgt  <= pick;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/demux_rr_ctrl.md
DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the data width carried through the 1-to-4 demux.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port in_valid  input  1  SHALL mark in_data valid from the upstream producer.
REQ-005 Port in_data  input  WIDTH  SHALL be the item to distribute.
REQ-006 Port in_ready  output  1  SHALL indicate the block accepts an item this cycle.
REQ-007 Port out_ready  input  4  SHALL be the per-lane consumer ready; bit i belongs to lane i.
REQ-008 Port out_valid  output  4  SHALL be the one-hot (or zero) per-lane valid.
REQ-009 Port out_data  output  WIDTH  SHALL be the held item, shared by all lanes (demux data input).
REQ-010 Port s0, s1  output  1 each  SHALL drive the demux selects; lane index = {s0,s1}, s0 the MSB (00->lane0 ... 11->lane3).
REQ-011 Port dcount  output  8  SHALL count delivered items.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE (no item held) and HOLD (one item held for lane tgt).
REQ-013 A 2-bit round-robin pointer ptr SHALL name the next lane to serve.
REQ-014 In IDLE: in_ready=1, out_valid=0; on in_valid=1 the block SHALL capture in_data into the hold register, set tgt per REQ-024/025, and enter HOLD next cycle.
REQ-015 In HOLD: out_valid SHALL be one-hot at bit tgt, out_data the held item, {s0,s1}=tgt; held item and tgt SHALL stay stable until delivered.
REQ-016 Delivery SHALL occur in a cycle where state=HOLD and out_ready[tgt]=1; out_ready on other lanes SHALL be ignored.
REQ-017 On delivery: ptr SHALL become tgt+1 modulo 4 (3 wraps to 0), dcount SHALL increment modulo 256 (255 wraps to 0).
REQ-018 in_ready SHALL equal (state==IDLE) OR (delivery this cycle); this combinational path from out_ready is intentional.
REQ-019 Delivery and in_valid in the same cycle SHALL capture the new item, stay in HOLD, and choose tgt from the post-increment ptr; no bubble.
REQ-020 Delivery without in_valid SHALL return to IDLE.
REQ-021 Latency SHALL be one cycle: an item accepted at edge N is presented on out_valid from cycle N+1.
REQ-022 In IDLE, {s0,s1} SHALL equal ptr and out_data SHALL hold its last value.
REQ-023 Capture with in_valid=0 or in HOLD without delivery SHALL never occur.

Configuration
REQ-024 With macro DEMUX_RR_SKIP_EN undefined, tgt at capture SHALL equal the current ptr (strict rotation, a stalled lane stalls all lanes).
REQ-025 With DEMUX_RR_SKIP_EN defined, tgt at capture SHALL be the first lane with out_ready=1 searching ptr, ptr+1, ptr+2, ptr+3 (mod 4); if none ready, tgt=ptr.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, ptr=0, tgt=0, hold register=0, dcount=0, out_valid=0, s0=s1=0, out_data=0.
REQ-027 Reset asserted in HOLD SHALL discard the held item without delivery or dcount increment.
REQ-028 While rst_n=0, in_ready SHALL be 0; first capture SHALL be possible at the first clk edge after rst_n deasserts.

Verification
REQ-029 Reset, then items 1,0,1,1 with out_ready=4'b1111 continuous -> out_valid 0001,0010,0100,1000 on consecutive cycles, {s0,s1}=00,01,10,11, dcount=4, no bubbles.
REQ-030 Hold out_ready[1]=0 for 5 cycles with item for lane1 -> out_valid=0010 and out_data stable for 5 cycles, in_ready=0; release -> delivered, ptr=2.
REQ-031 Deliver 257 items -> dcount wraps to 1; ptr wraps 3->0 every fourth item.
REQ-032 Assert rst_n=0 mid-HOLD -> outputs at reset values immediately (asynchronous), dcount unchanged from 0 after reset, no delivery.
REQ-033 DEMUX_RR_SKIP_EN defined, ptr=0, out_ready=4'b0100 at capture -> tgt=2, out_valid=0100, {s0,s1}=10, ptr=3 after delivery; undefined -> tgt=0, stalls.
